// File: rtl/axis_trigger_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_trigger_capture_pkg
//  Description : State encoding and length helper shared by the trigger
//                capture block and its sub-modules.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_trigger_capture_pkg;

   // Capture sequencer states, explicit 3-bit encoding.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRE   = 3'd1,
      ARMED = 3'd2,
      POST  = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Post-trigger length including the trigger sample itself; never below 1,
   // so a frame always closes on (or after) the trigger sample.
   function automatic logic [31:0] calc_post_len(input logic [31:0] tot,
                                                 input logic [31:0] pre);
      if (tot <= pre) begin
         calc_post_len = 32'd1;
      end else begin
         calc_post_len = tot - pre;
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/axis_trigger_capture_cntr.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_capture_cntr
//  Description : Loadable down-counter with enable and zero flag. Load has
//                priority over decrement.
//  Revision    : 1.0 - initial release
// ============================================================================
module trigger_capture_cntr #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: load wins, otherwise decrement when enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en) begin
         cnt_d = cnt_q - WIDTH'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/axis_trigger_capture.sv
`default_nettype none
// ============================================================================
//  Module      : axis_trigger_capture
//  Description : Frames one triggered acquisition on an AXI-Stream sample
//                path: pre-trigger samples, wait for trigger, post-trigger
//                samples, tlast, and trigger position report.
//  Options     : AXIS_TRIGGER_CAPTURE_TIMEOUT_EN adds tmo_data and an
//                auto-trigger after tmo_data cycles spent in ARMED.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_trigger_capture
   import axis_trigger_capture_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int CNTR_WIDTH       = 16
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic                        run_flag,
   input  logic [CNTR_WIDTH-1:0]       pre_data,
   input  logic [CNTR_WIDTH-1:0]       tot_data,
   input  logic                        trg_flag,
`ifdef AXIS_TRIGGER_CAPTURE_TIMEOUT_EN
   input  logic [CNTR_WIDTH-1:0]       tmo_data,
`endif
   output logic                        trg_armed,
   output logic                        done_flag,
   output logic [CNTR_WIDTH-1:0]       sts_data,
   output logic                        s_axis_tready,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   output logic                        m_axis_tlast,
   input  logic                        m_axis_tready
);

   localparam logic [CNTR_WIDTH-1:0] c_one = CNTR_WIDTH'(1);
   localparam logic [CNTR_WIDTH-1:0] c_two = CNTR_WIDTH'(2);

   state_t                state_q,    state_d;
   logic                  run_q,      run_d;
   logic                  arm_q,      arm_d;
   logic [CNTR_WIDTH-1:0] post_len_q, post_len_d;
   logic [CNTR_WIDTH-1:0] pos_q,      pos_d;
   logic [CNTR_WIDTH-1:0] sts_q,      sts_d;

   logic active;
   logic accept;
   logic trig_cond;
   logic tmo_hit;
   logic pre_load, pre_dec, pre_zero;
   logic post_load, post_dec, post_zero;

`ifdef AXIS_TRIGGER_CAPTURE_TIMEOUT_EN
   logic [CNTR_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;

   // Cycle counter while armed; it parks on the threshold so the hit stays
   // asserted until a sample is actually accepted as the auto-trigger.
   always_comb begin
      tmo_hit   = (tmo_data != '0) && (tmo_cnt_q == tmo_data);
      tmo_cnt_d = '0;
      if (state_q == ARMED) begin
         tmo_cnt_d = tmo_hit ? tmo_cnt_q : tmo_cnt_q + c_one;
      end
   end

   // Timeout counter register.
   always_ff @(posedge aclk) begin
      if (areset) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Stream plumbing: frame states pass ready/valid straight through, idle
   // states swallow the input stream.
   always_comb begin
      active        = (state_q == PRE) || (state_q == ARMED) || (state_q == POST);
      s_axis_tready = active ? m_axis_tready : 1'b1;
      m_axis_tvalid = active & s_axis_tvalid;
      m_axis_tdata  = s_axis_tdata;
      accept        = s_axis_tvalid & s_axis_tready;
      trig_cond     = s_axis_tvalid & (trg_flag | tmo_hit);
      run_d         = run_flag;
      arm_d         = run_flag & ~run_q;
   end

   // Sequencer next state, counter controls and tlast.
   always_comb begin
      state_d      = state_q;
      post_len_d   = post_len_q;
      pos_d        = pos_q;
      sts_d        = sts_q;
      pre_load     = 1'b0;
      pre_dec      = 1'b0;
      post_load    = 1'b0;
      post_dec     = 1'b0;
      m_axis_tlast = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (arm_q) begin
               post_len_d = CNTR_WIDTH'(calc_post_len(32'(tot_data), 32'(pre_data)));
               pos_d      = '0;
               sts_d      = '0;
               if (pre_data == '0) begin
                  state_d = ARMED;
               end else begin
                  pre_load = 1'b1;
                  state_d  = PRE;
               end
            end
         end
         PRE: begin
            // Counter holds samples remaining minus one; trg_flag ignored.
            if (accept) begin
               pos_d = pos_q + c_one;
               if (pre_zero) begin
                  state_d = ARMED;
               end else begin
                  pre_dec = 1'b1;
               end
            end
         end
         ARMED: begin
            m_axis_tlast = trig_cond & (post_len_q == c_one);
            if (trig_cond && s_axis_tready) begin
               sts_d = pos_q;
               if (tmo_hit && !trg_flag) begin
                  sts_d[CNTR_WIDTH-1] = 1'b1;
               end
               if (post_len_q == c_one) begin
                  state_d = DONE;
               end else begin
                  // Trigger sample already counted; load remaining-minus-one.
                  post_load = 1'b1;
                  state_d   = POST;
               end
            end else if (accept) begin
               pos_d = pos_q + c_one;
            end
         end
         POST: begin
            m_axis_tlast = s_axis_tvalid & post_zero;
            if (accept) begin
               if (post_zero) begin
                  state_d = DONE;
               end else begin
                  post_dec = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer and bookkeeping registers.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q    <= IDLE;
         run_q      <= 1'b0;
         arm_q      <= 1'b0;
         post_len_q <= '0;
         pos_q      <= '0;
         sts_q      <= '0;
      end else begin
         state_q    <= state_d;
         run_q      <= run_d;
         arm_q      <= arm_d;
         post_len_q <= post_len_d;
         pos_q      <= pos_d;
         sts_q      <= sts_d;
      end
   end

   trigger_capture_cntr #(.WIDTH(CNTR_WIDTH)) u_pre_cntr (
      .clk      (aclk),
      .rst      (areset),
      .load     (pre_load),
      .load_val (pre_data - c_one),
      .en       (pre_dec),
      .zero     (pre_zero)
   );

   trigger_capture_cntr #(.WIDTH(CNTR_WIDTH)) u_post_cntr (
      .clk      (aclk),
      .rst      (areset),
      .load     (post_load),
      .load_val (post_len_q - c_two),
      .en       (post_dec),
      .zero     (post_zero)
   );

   assign trg_armed = (state_q == ARMED);
   assign done_flag = (state_q == DONE);
   assign sts_data  = sts_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_trigger_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_trigger_capture
//  Description : Self-checking bench for axis_trigger_capture. Directed
//                vector table plus randomized frames against a frame model
//                derived from the capture rules; abort-by-reset sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_trigger_capture;

   localparam int DW = 32;
   localparam int CW = 16;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic          run_flag = 1'b0;
   logic [CW-1:0] pre_data = '0;
   logic [CW-1:0] tot_data = '0;
   logic          trg_flag = 1'b0;
   logic          trg_armed, done_flag;
   logic [CW-1:0] sts_data;
   logic          s_axis_tready;
   logic [DW-1:0] s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid, m_axis_tlast;
   logic          m_axis_tready = 1'b1;
`ifdef AXIS_TRIGGER_CAPTURE_TIMEOUT_EN
   logic [CW-1:0] tmo_data = '0;
`endif

   always #5 aclk = ~aclk;

   axis_trigger_capture #(.AXIS_TDATA_WIDTH(DW), .CNTR_WIDTH(CW)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .run_flag      (run_flag),
      .pre_data      (pre_data),
      .tot_data      (tot_data),
      .trg_flag      (trg_flag),
`ifdef AXIS_TRIGGER_CAPTURE_TIMEOUT_EN
      .tmo_data      (tmo_data),
`endif
      .trg_armed     (trg_armed),
      .done_flag     (done_flag),
      .sts_data      (sts_data),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready)
   );

   typedef struct {
      int          pre;
      int          tot;
      logic [63:0] mask;    // bit k = trg_flag carried by input sample k
      bit          rnd;     // random valid gaps and ready backpressure
      int          exp_n;   // expected frame length in beats
      int          exp_sts; // expected trigger index
   } vec_t;

   int total = 0;
   int bad   = 0;
   logic [DW:0] beats[$];   // {tlast, tdata} of every output handshake

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Frame model: trigger is the first flagged sample at or after the
   // pre-trigger region; the frame then holds post_len samples from it.
   function automatic int model_trig(input int pre, input logic [63:0] mask);
      for (int i = pre; i < 64; i++) begin
         if (mask[i]) return i;
      end
      return -1;
   endfunction

   function automatic int model_post(input int pre, input int tot);
      return (tot <= pre) ? 1 : tot - pre;
   endfunction

   task automatic arm(input int pre, input int tot);
      @(negedge aclk);
      run_flag      = 1'b0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      pre_data      = CW'(pre);
      tot_data      = CW'(tot);
      repeat (2) @(negedge aclk);
      run_flag = 1'b1;
      trg_flag = 1'b1;   // stray trigger with no valid sample must be ignored
      repeat (4) @(negedge aclk);
      trg_flag = 1'b0;
   endtask

   task automatic stream(input logic [63:0] mask, input bit rnd, input logic [31:0] base,
                         input int stop_beats, output bit timed_out);
      int k = 0;
      int cyc = 0;
      bit hold = 0;
      timed_out = 1'b1;
      while (cyc < 2000) begin
         @(negedge aclk);
         if (!hold) s_axis_tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         s_axis_tdata  = base + 32'(k);
         if (s_axis_tvalid) trg_flag = (k < 64) ? mask[k] : 1'b0;
         else               trg_flag = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         #1;
         if (done_flag) begin
            timed_out = 1'b0;
            break;
         end
         if (m_axis_tvalid && m_axis_tready) beats.push_back({m_axis_tlast, m_axis_tdata});
         hold = s_axis_tvalid && !s_axis_tready;
         if (s_axis_tvalid && s_axis_tready) k++;
         cyc++;
         if (beats.size() >= stop_beats) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic run_frame(input vec_t v, input logic [31:0] base, input string tag);
      bit to;
      int extra = 0;
      beats.delete();
      arm(v.pre, v.tot);
      check({tag, "_armed_before_data"}, 64'(trg_armed), 64'(v.pre == 0));
      stream(v.mask, v.rnd, base, 100000, to);
      check({tag, "_timeout"}, 64'(to), 64'd0);
      check({tag, "_beat_count"}, 64'(beats.size()), 64'(v.exp_n));
      for (int i = 0; i < beats.size(); i++) begin
         check({tag, "_data"}, 64'(beats[i][DW-1:0]), 64'(base + 32'(i)));
         check({tag, "_tlast"}, 64'(beats[i][DW]), 64'(i == v.exp_n - 1));
      end
      check({tag, "_sts"}, 64'(sts_data), 64'(v.exp_sts));
      check({tag, "_armed_after"}, 64'(trg_armed), 64'd0);
      // run_flag stays high: no re-arm, no more beats, done holds.
      repeat (5) begin
         @(negedge aclk);
         s_axis_tvalid = 1'b1;
         trg_flag      = 1'b1;
         #1;
         if (m_axis_tvalid) extra++;
      end
      check({tag, "_no_beats_after_done"}, 64'(extra), 64'd0);
      check({tag, "_done_held"}, 64'(done_flag), 64'd1);
   endtask

   vec_t vecs[8];

   initial begin
      bit   to;
      int   tlast_cnt;
      vec_t rv;
      int   t0;

      vecs[0] = '{pre: 4, tot: 10, mask: 64'h40,  rnd: 1'b0, exp_n: 12, exp_sts: 6};
      vecs[1] = '{pre: 0, tot: 3,  mask: 64'h1,   rnd: 1'b0, exp_n: 3,  exp_sts: 0};
      vecs[2] = '{pre: 5, tot: 2,  mask: 64'h20,  rnd: 1'b0, exp_n: 6,  exp_sts: 5};
      vecs[3] = '{pre: 3, tot: 6,  mask: 64'hF,   rnd: 1'b0, exp_n: 6,  exp_sts: 3};
      vecs[4] = '{pre: 8, tot: 32, mask: 64'h100, rnd: 1'b1, exp_n: 32, exp_sts: 8};
      vecs[5] = '{pre: 2, tot: 2,  mask: 64'h10,  rnd: 1'b0, exp_n: 5,  exp_sts: 4};
      vecs[6] = '{pre: 0, tot: 1,  mask: 64'h1,   rnd: 1'b0, exp_n: 1,  exp_sts: 0};
      vecs[7] = '{pre: 3, tot: 5,  mask: 64'h84,  rnd: 1'b0, exp_n: 9,  exp_sts: 7};

      // Reset state, with a valid sample offered.
      repeat (3) @(negedge aclk);
      s_axis_tvalid = 1'b1;
      #1;
      check("rst_trg_armed", 64'(trg_armed), 64'd0);
      check("rst_done", 64'(done_flag), 64'd0);
      check("rst_sts", 64'(sts_data), 64'd0);
      check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
      check("rst_s_tready", 64'(s_axis_tready), 64'd1);
      @(negedge aclk);
      areset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_frame(vecs[i], 32'hA000_0000 + 32'(i << 8), $sformatf("vec%0d", i));
      end

      // Randomized frames, expectations from the frame model.
      for (int f = 0; f < 12; f++) begin
         rv.pre  = $urandom_range(0, 12);
         rv.tot  = $urandom_range(0, 24);
         t0      = rv.pre + $urandom_range(0, 10);
         rv.mask = ({$urandom, $urandom} & {$urandom, $urandom}) | (64'd1 << t0);
         rv.rnd  = 1'b1;
         rv.exp_sts = model_trig(rv.pre, rv.mask);
         rv.exp_n   = rv.exp_sts + model_post(rv.pre, rv.tot);
         run_frame(rv, 32'hB000_0000 + 32'(f << 8), $sformatf("rnd%0d", f));
      end

      // Abort mid-POST by reset, then a clean re-armed frame.
      beats.delete();
      arm(2, 10);
      stream(64'h4, 1'b0, 32'hC000_0000, 5, to);
      check("abort_reach_post", 64'(to), 64'd0);
      @(negedge aclk);
      run_flag      = 1'b0;
      areset        = 1'b1;
      s_axis_tvalid = 1'b1;
      @(negedge aclk);
      #1;
      tlast_cnt = 0;
      foreach (beats[i]) if (beats[i][DW]) tlast_cnt++;
      check("abort_no_tlast", 64'(tlast_cnt), 64'd0);
      check("abort_trg_armed", 64'(trg_armed), 64'd0);
      check("abort_done", 64'(done_flag), 64'd0);
      check("abort_sts", 64'(sts_data), 64'd0);
      check("abort_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("abort_m_tlast", 64'(m_axis_tlast), 64'd0);
      areset = 1'b0;
      rv = '{pre: 2, tot: 4, mask: 64'h4, rnd: 1'b0, exp_n: 4, exp_sts: 2};
      run_frame(rv, 32'hD000_0000, "rearm");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
